stage_wb: RTL and testbench

Write-back stage of the RISC-V pipeline: the writer end of the register file that the decode stage reads. Accepts retiring instructions from the memory stage over a valid/ready handshake, waits for load data from data memory where needed, aligns and sign/zero-extends load data, and drives the registered `write_reg` / `write_data` / `reg_write` triple into the decode stage's register-file write port. Also keeps a retired-instruction counter and a sticky memory-protocol error flag.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/load_align.sv | 37 +++
 rtl/stage_wb.sv | 107 ++++++++++
 tb/tb_stage_wb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: load funct3 codes and the write-back stage state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Selects and extends the addressed byte/halfword lane of an aligned 32-bit memory word.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    // Halfword lane comes from off[1] only; an odd offset is not trapped.
    half_v = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  result = {24'd0, byte_v};
      F3_LH:   result = {{16{half_v[15]}}, half_v};
      F3_LHU:  result = {16'd0, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: retires instructions into the register file, waiting for load data when needed.
// Handshake: a transfer happens on a rising edge where in_valid && in_ready; in_ready depends on state only.
module stage_wb
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        reg_write,
  output logic [31:0] retired,
  output logic        mem_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  wb_state_e   state;
  logic [4:0]  rd_q;
  logic        regwrite_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic        timeout_fire;
  logic [31:0] load_data;

  load_align u_load_align (
    .funct3 (funct3_q),
    .off    (off_q),
    .word   (mem_rdata),
    .result (load_data)
  );

  assign in_ready     = (state == WB_IDLE);
  assign cnt_nxt      = cnt_q + CW'(1);
  // Fires in the WAIT_MEM cycle where the counter reaches TIMEOUT; a response in that cycle still wins.
  assign timeout_fire = (TIMEOUT != 0) && (cnt_nxt == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WB_IDLE;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      cnt_q      <= '0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
      reg_write  <= 1'b0;
      retired    <= 32'd0;
      mem_err    <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (mem_rvalid) mem_err <= 1'b1;
          if (in_valid) begin
            if (MemtoReg) begin
              rd_q       <= rd;
              regwrite_q <= RegWrite;
              funct3_q   <= funct3;
              off_q      <= alu_result[1:0];
              cnt_q      <= '0;
              state      <= WB_WAIT_MEM;
            end else begin
              if (RegWrite && (rd != 5'd0)) begin
                reg_write  <= 1'b1;
                write_reg  <= rd;
                write_data <= alu_result;
              end
              retired <= retired + 32'd1;
            end
          end
        end
        WB_WAIT_MEM: begin
          if (mem_rvalid) begin
            if (regwrite_q && (rd_q != 5'd0)) begin
              reg_write  <= 1'b1;
              write_reg  <= rd_q;
              write_data <= load_data;
            end
            retired <= retired + 32'd1;
            state   <= WB_IDLE;
          end else if (timeout_fire) begin
            mem_err <= 1'b1;
            state   <= WB_IDLE;
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_wb.sv
// Bench for stage_wb: directed and randomized retire traffic against a transaction-level model.
module tb_stage_wb;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        RegWrite;
  logic        MemtoReg;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] retired;
  logic        mem_err;

  stage_wb #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_result (alu_result),
    .rd         (rd),
    .funct3     (funct3),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .retired    (retired),
    .mem_err    (mem_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [36:0] exp_q[$];   // {rd, data} of every register-file write expected
  logic [31:0] exp_retired = 32'd0;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: pick the addressed lane by shifting, then extend by arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] sh;
    int          v;
    case (f3)
      3'b000, 3'b100: begin
        sh = w >> (8 * off);
        v  = int'(sh & 32'hFF);
        if (f3 == 3'b000 && v >= 128) v = v - 256;
        return 32'(v);
      end
      3'b001, 3'b101: begin
        sh = w >> (off[1] ? 16 : 0);
        v  = int'(sh & 32'hFFFF);
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      default: return w;
    endcase
  endfunction

  // scoreboard: every reg_write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && reg_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, write_reg}, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("write_reg", {27'd0, write_reg}, {27'd0, e[36:32]});
        check("write_data", write_data, e[31:0]);
      end
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the op completes
  task automatic alu_op(input logic [4:0] r, input logic [31:0] val, input logic rw);
    check("in_ready_alu", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; MemtoReg = 1'b0; RegWrite = rw; rd = r; alu_result = val;
    funct3 = 3'($urandom_range(0, 7));
    if (rw && r != 5'd0) exp_q.push_back({r, val});
    exp_retired = exp_retired + 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_op(input logic [4:0] r, input logic [31:0] addr, input logic [2:0] f3,
                         input logic rw, input logic [31:0] word, input int delay);
    in_valid = 1'b1; MemtoReg = 1'b1; RegWrite = rw; rd = r; alu_result = addr; funct3 = f3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_result = $urandom; funct3 = 3'($urandom_range(0, 7)); rd = 5'($urandom);
    check("in_ready_wait", {31'd0, in_ready}, 32'd0);
    repeat (delay) begin @(posedge clk); #1; end
    mem_rvalid = 1'b1; mem_rdata = word;
    if (rw && r != 5'd0) exp_q.push_back({r, ref_load(f3, addr[1:0], word)});
    exp_retired = exp_retired + 32'd1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    check("in_ready_after_load", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    exp_q.delete();
    exp_retired = 32'd0;
    exp_err = 1'b0;
  endtask

  initial begin
    int n;
    in_valid = 0; alu_result = 0; rd = 0; funct3 = 0; RegWrite = 0; MemtoReg = 0;
    mem_rvalid = 0; mem_rdata = 0;
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(posedge clk); #1;

    check("rst_reg_write", {31'd0, reg_write}, 32'd0);
    check("rst_write_reg", {27'd0, write_reg}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_mem_err", {31'd0, mem_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single add, then back-to-back ops to x1, x2, x0
    alu_op(5'd5, 32'h12345678, 1'b1);
    check("add_retired", retired, 32'd1);
    check("add_write_data", write_data, 32'h12345678);
    alu_op(5'd1, 32'h11111111, 1'b1);
    alu_op(5'd2, 32'h22222222, 1'b1);
    alu_op(5'd0, 32'h33333333, 1'b1);
    check("b2b_retired", retired, exp_retired);
    check("x0_hold_data", write_data, 32'h22222222);

    // load lanes with three wait cycles
    load_op(5'd7, 32'h1003, 3'b000, 1'b1, 32'h80FF0011, 3);
    check("lb_data", write_data, 32'hFFFFFF80);
    load_op(5'd7, 32'h1003, 3'b100, 1'b1, 32'h80FF0011, 3);
    check("lbu_data", write_data, 32'h00000080);
    load_op(5'd8, 32'h1002, 3'b001, 1'b1, 32'h80FF0011, 3);
    check("lh_data", write_data, 32'hFFFF80FF);
    load_op(5'd8, 32'h1002, 3'b101, 1'b1, 32'h80FF0011, 3);
    check("lhu_data", write_data, 32'h000080FF);

    // response in the very cycle the timeout would fire
    load_op(5'd9, 32'h2000, 3'b010, 1'b1, 32'hCAFEF00D, TO - 1);
    check("tie_data", write_data, 32'hCAFEF00D);
    check("tie_mem_err", {31'd0, mem_err}, 32'd0);

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 0)
        alu_op(5'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
      else
        load_op(5'($urandom), $urandom, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, TO - 1));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    check("rand_retired", retired, exp_retired);
    check("rand_mem_err", {31'd0, mem_err}, 32'd0);

    // timeout: no response at all
    in_valid = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; rd = 5'd3; alu_result = 32'h3000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (in_ready) break;
    end
    exp_err = 1'b1;
    check("timeout_cycles", 32'(n), 32'(TO));
    check("timeout_mem_err", {31'd0, mem_err}, {31'd0, exp_err});
    check("timeout_in_ready", {31'd0, in_ready}, 32'd1);
    check("timeout_retired", retired, exp_retired);
    idle_cycles(1);

    // unexpected response while idle, sticky until reset
    do_reset();
    check("rst2_mem_err", {31'd0, mem_err}, 32'd0);
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    exp_err = 1'b1;
    check("idle_rvalid_err", {31'd0, mem_err}, {31'd0, exp_err});
    alu_op(5'd4, 32'hA5A5A5A5, 1'b1);
    load_op(5'd6, 32'h0001, 3'b100, 1'b1, 32'h0000AB00, 2);
    check("err_sticky", {31'd0, mem_err}, 32'd1);
    check("err_retired", retired, exp_retired);

    // reset in the middle of a pending load, then a stray response
    do_reset();
    in_valid = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; rd = 5'd10; alu_result = 32'h4000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle_cycles(2);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    exp_err = 1'b1;
    idle_cycles(2);
    check("midrst_retired", retired, 32'd0);
    check("midrst_mem_err", {31'd0, mem_err}, {31'd0, exp_err});
    check("midrst_write_data", write_data, 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
